// File: rtl/marian_ctrl_pkg.sv
// Shared register offsets, AXI response codes and FSM encodings for the
// Marian control/exit/UART register slice.
package marian_ctrl_pkg;

    localparam logic [5:0] EXIT_OFF       = 6'h00;
    localparam logic [5:0] UART_TX_OFF    = 6'h08;
    localparam logic [5:0] UART_STAT_OFF  = 6'h10;
    localparam logic [5:0] BOOT_READY_OFF = 6'h30;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_W_DATA,
        ST_W_RESP,
        ST_R_RESP
    } ctrl_state_e;

    typedef enum logic [2:0] {
        SEL_EXIT,
        SEL_UART,
        SEL_STAT,
        SEL_BOOT,
        SEL_NONE
    } reg_sel_e;

endpackage

// File: rtl/marian_uart_tx.sv
// 8N1 UART transmitter; busy from the accepting cycle through the end of the stop bit.
module marian_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       tx_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;

    // bit_idx: 0 = start, 1..8 = data, 9 = stop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o   <= 1'b0;
            tx_o     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (!busy_o) begin
            if (valid_i) begin
                busy_o   <= 1'b1;
                tx_o     <= 1'b0;
                shreg    <= data_i;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end else if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
                busy_o <= 1'b0;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                if (bit_idx == 4'd8) begin
                    tx_o <= 1'b1;
                end else begin
                    tx_o  <= shreg[0];
                    shreg <= shreg >> 1;
                end
            end
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/marian_ctrl_uart.sv
// Single-beat AXI slave holding BOOT_READY, EXIT/tohost and a byte UART TX.
module marian_ctrl_uart
    import marian_ctrl_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH  = 64,
    parameter int unsigned             DATA_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0]   CTRL_BASE   = 'h0600_0000,
    parameter int unsigned             CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned             BAUD_RATE   = 115200
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_last_i,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    output logic [1:0]              b_resp_o,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_last_o,
    output logic                    boot_ready_o,
    output logic [DATA_WIDTH-1:0]   exit_o,
    output logic                    uart_tx_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    ctrl_state_e state;
    reg_sel_e    wr_sel;
    reg_sel_e    rd_sel;
    logic        live;
    logic        uart_busy;
    logic        uart_valid;
    logic        unused_bits;

    function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] a);
        if (a[ADDR_WIDTH-1:6] != CTRL_BASE[ADDR_WIDTH-1:6]) return SEL_NONE;
        case ({a[5:3], 3'b000})
            EXIT_OFF:       return SEL_EXIT;
            UART_TX_OFF:    return SEL_UART;
            UART_STAT_OFF:  return SEL_STAT;
            BOOT_READY_OFF: return SEL_BOOT;
            default:        return SEL_NONE;
        endcase
    endfunction

    assign rd_sel      = decode(ar_addr_i);
    assign unused_bits = ^{w_last_i, aw_addr_i[2:0], ar_addr_i[2:0]};

    // live gates the ready outputs low while rst_i is held
    assign aw_ready_o = live && (state == ST_IDLE);
    assign ar_ready_o = live && (state == ST_IDLE) && !aw_valid_i;
    assign w_ready_o  = (state == ST_W_DATA) && !((wr_sel == SEL_UART) && uart_busy);
    assign uart_valid = w_valid_i && w_ready_o && (wr_sel == SEL_UART) && w_strb_i[0];
    assign r_last_o   = 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            live         <= 1'b0;
            wr_sel       <= SEL_NONE;
            b_valid_o    <= 1'b0;
            b_resp_o     <= OKAY;
            r_valid_o    <= 1'b0;
            r_data_o     <= '0;
            r_resp_o     <= OKAY;
            exit_o       <= '0;
            boot_ready_o <= 1'b0;
        end else begin
            live <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (aw_valid_i && aw_ready_o) begin
                        wr_sel <= decode(aw_addr_i);
                        state  <= ST_W_DATA;
                    end else if (ar_valid_i && ar_ready_o) begin
                        r_valid_o <= 1'b1;
                        r_resp_o  <= OKAY;
                        r_data_o  <= '0;
                        case (rd_sel)
                            SEL_EXIT: r_data_o    <= exit_o;
                            SEL_STAT: r_data_o[0] <= uart_busy;
                            SEL_BOOT: r_data_o[0] <= boot_ready_o;
                            SEL_NONE: r_resp_o    <= DECERR;
                            default:  ;
                        endcase
                        state <= ST_R_RESP;
                    end
                end
                ST_W_DATA: begin
                    if (w_valid_i && w_ready_o) begin
                        b_valid_o <= 1'b1;
                        b_resp_o  <= OKAY;
                        case (wr_sel)
                            SEL_EXIT: begin
                                for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
                                    if (w_strb_i[i]) exit_o[i*8 +: 8] <= w_data_i[i*8 +: 8];
                                end
                            end
                            SEL_BOOT: if (w_strb_i[0]) boot_ready_o <= w_data_i[0];
                            SEL_STAT: b_resp_o <= SLVERR;
                            SEL_NONE: b_resp_o <= DECERR;
                            default:  ;
                        endcase
                        state <= ST_W_RESP;
                    end
                end
                ST_W_RESP: begin
                    if (b_ready_i) begin
                        b_valid_o <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_R_RESP: begin
                    if (r_ready_i) begin
                        r_valid_o <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    marian_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .valid_i(uart_valid),
        .data_i (w_data_i[7:0]),
        .busy_o (uart_busy),
        .tx_o   (uart_tx_o)
    );

endmodule

// File: tb/tb_marian_ctrl_uart.sv
// Directed bench for marian_ctrl_uart with a fast baud (10 clocks per bit).
module tb_marian_ctrl_uart;

    localparam int unsigned CPB  = 10;
    localparam logic [63:0] BASE = 64'h0600_0000;

    logic        tb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_valid = 1'b0, aw_ready;
    logic [63:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [63:0] ar_addr = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        boot_ready;
    logic [63:0] exit_val;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc;
    logic pre_boot, post_boot, pre_tx, post_tx;
    logic [7:0] rx_q[$];

    marian_ctrl_uart #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .CTRL_BASE  (BASE),
        .CLK_FREQ_HZ(1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk_i(tb_clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
        .w_strb_i(w_strb), .w_last_i(1'b1),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .boot_ready_o(boot_ready), .exit_o(exit_val), .uart_tx_o(uart_tx)
    );

    always #5 tb_clk = ~tb_clk;
    always @(posedge tb_clk) cyc <= cyc + 1;

    // Independent 8N1 receiver sampling mid-bit from the falling start edge
    initial begin
        logic prev;
        logic [7:0] rb;
        prev = 1'b1;
        rb = '0;
        forever begin
            @(negedge tb_clk);
            if (prev === 1'b1 && uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge tb_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge tb_clk);
                    rb[i] = uart_tx;
                end
                repeat (CPB) @(negedge tb_clk);
                if (uart_tx === 1'b1) rx_q.push_back(rb);
            end
            prev = uart_tx;
        end
    end

    // All tasks start and end on a falling edge.
    task automatic wait_until(input int target);
        if (cyc > target) begin
            $display("FAIL wait_until: cycle %0d already past target %0d", cyc, target);
            $fatal(1);
        end
        while (cyc < target) @(negedge tb_clk);
    endtask

    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, output logic [1:0] resp);
        int n;
        aw_valid = 1'b1; aw_addr = addr;
        w_valid = 1'b1; w_data = data; w_strb = strb;
        #1;
        n = 0;
        while (!aw_ready && n < 200) begin @(negedge tb_clk); n++; end
        if (!aw_ready) begin $display("FAIL aw_timeout: aw_ready=%b required 1", aw_ready); $fatal(1); end
        @(negedge tb_clk);
        aw_valid = 1'b0;
        n = 0;
        while (!w_ready && n < 400) begin @(negedge tb_clk); n++; end
        if (!w_ready) begin $display("FAIL w_timeout: w_ready=%b required 1", w_ready); $fatal(1); end
        pre_boot = boot_ready; pre_tx = uart_tx;
        @(negedge tb_clk);
        hs_cyc = cyc; post_boot = boot_ready; post_tx = uart_tx;
        w_valid = 1'b0; b_ready = 1'b1;
        if (!b_valid) begin $display("FAIL b_timeout: b_valid=%b required 1", b_valid); $fatal(1); end
        resp = b_resp;
        @(negedge tb_clk);
        b_ready = 1'b0;
    endtask

    task automatic axi_read(input logic [63:0] addr, output logic [63:0] data, output logic [1:0] resp);
        int n;
        ar_valid = 1'b1; ar_addr = addr;
        #1;
        n = 0;
        while (!ar_ready && n < 200) begin @(negedge tb_clk); n++; end
        if (!ar_ready) begin $display("FAIL ar_timeout: ar_ready=%b required 1", ar_ready); $fatal(1); end
        @(negedge tb_clk);
        ar_valid = 1'b0; r_ready = 1'b1;
        if (!r_valid) begin $display("FAIL r_timeout: r_valid=%b required 1", r_valid); $fatal(1); end
        data = r_data; resp = r_resp;
        @(negedge tb_clk);
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge tb_clk);
        checks++;
        if ({uart_tx, boot_ready, aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_outputs: tx/boot/awr/arr/wr/bv/rv=%b required 1000000",
                     {uart_tx, boot_ready, aw_ready, ar_ready, w_ready, b_valid, r_valid});
        end
        checks++;
        if (exit_val !== 64'd0) begin errors++; $display("FAIL reset_exit: got %h required 0", exit_val); end
        rst = 1'b0;
        repeat (2) @(negedge tb_clk);
    endtask

    task automatic test_boot();
        logic [1:0] resp; logic [63:0] d;
        axi_write(BASE + 64'h30, 64'd1, 8'hFF, resp);
        checks++;
        if (resp !== 2'd0) begin errors++; $display("FAIL boot_bresp: got %0d required 0", resp); end
        checks++;
        if ({pre_boot, post_boot} !== 2'b01) begin
            errors++; $display("FAIL boot_timing: before/after=%b required 01", {pre_boot, post_boot});
        end
        axi_read(BASE + 64'h30, d, resp);
        checks++;
        if (d !== 64'd1 || resp !== 2'd0) begin errors++; $display("FAIL boot_read: got %h/%0d required 1/0", d, resp); end
        axi_read(BASE + 64'h34, d, resp);
        checks++;
        if (d !== 64'd1 || resp !== 2'd0) begin errors++; $display("FAIL boot_read_low_bits: got %h/%0d required 1/0", d, resp); end
    endtask

    task automatic test_exit();
        logic [1:0] resp; logic [63:0] d;
        axi_write(BASE, 64'd1, 8'hFF, resp);
        checks++;
        if (exit_val !== 64'd1) begin errors++; $display("FAIL exit_pass: got %h required 1", exit_val); end
        axi_write(BASE, 64'd7, 8'hFF, resp);
        checks++;
        if (exit_val[0] !== 1'b1 || (exit_val >> 1) !== 64'd3) begin
            errors++; $display("FAIL exit_code: got %h required done=1 code=3", exit_val);
        end
        axi_write(BASE, 64'hFFFF_FFFF_FFFF_FFFF, 8'h02, resp);
        axi_read(BASE, d, resp);
        checks++;
        if (d !== 64'hFF07 || exit_val !== 64'hFF07) begin
            errors++; $display("FAIL exit_strobe: read %h port %h required ff07", d, exit_val);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [63:0] d;
        axi_read(BASE + 64'h20, d, resp);
        checks++;
        if (d !== 64'd0 || resp !== 2'd3) begin errors++; $display("FAIL decerr_read: got %h/%0d required 0/3", d, resp); end
        axi_write(BASE + 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp);
        checks++;
        if (resp !== 2'd3) begin errors++; $display("FAIL decerr_write: got %0d required 3", resp); end
        checks++;
        if (exit_val !== 64'hFF07 || boot_ready !== 1'b1) begin
            errors++; $display("FAIL decerr_no_effect: exit %h boot %b required ff07/1", exit_val, boot_ready);
        end
        axi_write(BASE + 64'h10, 64'hFF, 8'hFF, resp);
        checks++;
        if (resp !== 2'd2) begin errors++; $display("FAIL status_slverr: got %0d required 2", resp); end
        axi_write(BASE + 64'h08, 64'h41, 8'h02, resp);
        axi_read(BASE + 64'h10, d, resp);
        checks++;
        if (d !== 64'd0 || resp !== 2'd0) begin errors++; $display("FAIL uart_nostrb: status %h/%0d required 0/0", d, resp); end
    endtask

    task automatic test_uart_frame();
        logic [1:0] resp; int c0;
        logic [9:0] frame;
        frame = {1'b1, 8'h41, 1'b0};
        rx_q.delete();
        axi_write(BASE + 64'h08, 64'h41, 8'hFF, resp);
        c0 = hs_cyc;
        checks++;
        if ({pre_tx, post_tx} !== 2'b10) begin errors++; $display("FAIL uart_start_edge: before/after=%b required 10", {pre_tx, post_tx}); end
        for (int k = 0; k < 10; k++) begin
            wait_until(c0 + k * CPB + 2);
            checks++;
            if (uart_tx !== frame[k]) begin errors++; $display("FAIL uart_bit%0d_early: got %b required %b", k, uart_tx, frame[k]); end
            wait_until(c0 + k * CPB + CPB - 1);
            checks++;
            if (uart_tx !== frame[k]) begin errors++; $display("FAIL uart_bit%0d_late: got %b required %b", k, uart_tx, frame[k]); end
        end
        wait_until(c0 + 10 * CPB + 1);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin errors++; $display("FAIL uart_rx: %0d bytes first %h required 1 byte 41", rx_q.size(), rx_q[0]); end
    endtask

    task automatic test_uart_status();
        logic [1:0] resp; logic [63:0] d; int c0;
        axi_write(BASE + 64'h08, 64'h55, 8'hFF, resp);
        c0 = hs_cyc;
        axi_read(BASE + 64'h10, d, resp);
        checks++;
        if (d !== 64'd1) begin errors++; $display("FAIL status_busy: got %h required 1", d); end
        wait_until(c0 + 99);
        axi_read(BASE + 64'h10, d, resp);
        checks++;
        if (d !== 64'd1) begin errors++; $display("FAIL status_stopbit_end: got %h required 1", d); end
        wait_until(c0 + 105);
        axi_write(BASE + 64'h08, 64'h55, 8'hFF, resp);
        c0 = hs_cyc;
        wait_until(c0 + 100);
        axi_read(BASE + 64'h10, d, resp);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL status_idle: got %h required 0", d); end
        wait_until(c0 + 110);
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp; int c0;
        rx_q.delete();
        axi_write(BASE + 64'h08, 64'h41, 8'hFF, resp);
        c0 = hs_cyc;
        axi_write(BASE + 64'h08, 64'hA5, 8'hFF, resp);
        checks++;
        if (hs_cyc != c0 + 10 * CPB + 1) begin errors++; $display("FAIL b2b_stall: second W at +%0d required +%0d", hs_cyc - c0, 10 * CPB + 1); end
        wait_until(hs_cyc + 10 * CPB + 2);
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h41 || rx_q[1] !== 8'hA5) begin
            errors++; $display("FAIL b2b_order: %0d bytes %h %h required 41 a5", rx_q.size(), rx_q[0], rx_q[1]);
        end
    endtask

    task automatic test_simultaneous();
        aw_valid = 1'b1; aw_addr = BASE; w_valid = 1'b1; w_data = 64'd5; w_strb = 8'hFF;
        ar_valid = 1'b1; ar_addr = BASE;
        #1;
        checks++;
        if ({aw_ready, ar_ready} !== 2'b10) begin errors++; $display("FAIL simul_arb: aw/ar ready=%b required 10", {aw_ready, ar_ready}); end
        @(negedge tb_clk);
        aw_valid = 1'b0;
        @(negedge tb_clk);
        w_valid = 1'b0; b_ready = 1'b1;
        checks++;
        if ({b_valid, r_valid} !== 2'b10) begin errors++; $display("FAIL simul_write_first: b/r valid=%b required 10", {b_valid, r_valid}); end
        @(negedge tb_clk);
        b_ready = 1'b0;
        @(negedge tb_clk);
        ar_valid = 1'b0; r_ready = 1'b1;
        checks++;
        if (r_valid !== 1'b1 || r_data !== 64'd5) begin errors++; $display("FAIL simul_read_after: valid %b data %h required 1/5", r_valid, r_data); end
        @(negedge tb_clk);
        r_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [1:0] resp; logic [63:0] d; int c0;
        axi_write(BASE + 64'h08, 64'h00, 8'hFF, resp);
        c0 = hs_cyc;
        wait_until(c0 + 30);
        checks++;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_low: got %b required 0", uart_tx); end
        rst = 1'b1;
        @(negedge tb_clk);
        checks++;
        if (uart_tx !== 1'b1 || exit_val !== 64'd0 || boot_ready !== 1'b0) begin
            errors++; $display("FAIL midframe_reset: tx %b exit %h boot %b required 1/0/0", uart_tx, exit_val, boot_ready);
        end
        rst = 1'b0;
        repeat (2) @(negedge tb_clk);
        axi_read(BASE + 64'h10, d, resp);
        checks++;
        if (d !== 64'd0) begin errors++; $display("FAIL midframe_busy: got %h required 0", d); end
    endtask

    initial begin
        @(negedge tb_clk);
        test_reset();
        test_boot();
        test_exit();
        test_errors();
        test_uart_frame();
        test_uart_status();
        test_back_to_back();
        test_simultaneous();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
